axis_video_sink_monitor: RTL and testbench
==========================================

# axis_video_sink_monitor

Synthesizable AXI4-Stream video sink that terminates the output of the keystone pipeline (or any video stage) and checks its framing. It accepts beats under a programmable backpressure control and tracks pixel/line position from SOF (`tuser`) and EOL (`tlast`). It flags framing violations as sticky errors and produces a per-frame signature and frame count. It is used on-chip as a stream terminator for self-test, and in simulation as the RTL counterpart of the stimulus driver.

## Interface
Parameters:
- `DATA_WIDTH`, 64: stream data width; only `tdata[31:0]` enters the signature.
- `FRAME_WIDTH`, 1920: pixels per line.
- `FRAME_HEIGHT`, 1080: lines per frame.

Ports:
- `aclk`  in  1  clock.
- `aresetn`  in  1  reset, synchronous, active-low.
- `aclken`  in  1  clock enable; when 0, no state changes and no transfers occur.
- `s_axis_video_tdata`  in  DATA_WIDTH  pixel data.
- `s_axis_video_tvalid`  in  1  beat valid.
- `s_axis_video_tready`  out  1  sink ready (registered).
- `s_axis_video_tuser`  in  1  start of frame.
- `s_axis_video_tlast`  in  1  end of line.
- `ready_en`  in  1  backpressure control; tready follows it with 1-cycle delay.
- `clear_err`  in  1  single-cycle pulse that clears the sticky error flags and `drop_count`.
- `x_pos`  out  16  beat index within the current line.
- `y_pos`  out  16  current line index.
- `frame_count`  out  32  frames completed.
- `drop_count`  out  16  beats discarded while waiting for SOF (saturating).
- `frame_sig`  out  32  signature of the last completed frame.
- `frame_done`  out  1  one-cycle pulse when a frame completes.
- `err_early_eol`  out  1  sticky: tlast before `x_pos == FRAME_WIDTH-1`.
- `err_late_eol`  out  1  sticky: no tlast at `x_pos == FRAME_WIDTH-1`.
- `err_sof_mid`  out  1  sticky: tuser received inside a frame.

## Operation
- A transfer occurs when `aclken & tvalid & tready` are all 1 at a rising edge of `aclk`.
- Two-state FSM:
  - **WAIT_SOF** (reset state):
    - Transfer with tuser=1: frame starts; go to IN_FRAME; `x_pos`=1, `y_pos`=0, signature seeded to `tdata[31:0]`.
    - Transfer with tuser=0: beat discarded; `drop_count`++ (saturates at 0xFFFF).
  - **IN_FRAME**:
    - Each transfer updates the signature: `sig <= {sig[30:0], sig[31]} ^ tdata[31:0]`.
    - Transfer with tuser=1: set `err_sof_mid`; restart the frame exactly as in WAIT_SOF. The partial frame is not counted.
- Line end occurs on the first of: tlast=1, or `x_pos == FRAME_WIDTH-1`.
  - tlast=1 with `x_pos < FRAME_WIDTH-1`: set `err_early_eol`.
  - `x_pos == FRAME_WIDTH-1` with tlast=0: set `err_late_eol`.
  - In all cases `x_pos` goes to 0 and `y_pos` increments.
- Frame end is a line end with `y_pos == FRAME_HEIGHT-1`. On frame end:
  - `frame_sig` takes the signature including the final beat.
  - `frame_count` increments (wraps at 2^32).
  - `frame_done` pulses.
  - FSM returns to WAIT_SOF; `x_pos` and `y_pos` go to 0.
- Simultaneous events in the same cycle:
  - tuser=1 and tlast=1 in one beat: SOF handling applies first; the tlast is then evaluated at `x_pos`=0, which sets `err_early_eol` unless `FRAME_WIDTH == 1`.
  - `clear_err` coinciding with a new error event: the set wins.
- Reset values: all counters, `frame_sig`, errors, `frame_done` and `tready` are 0; FSM is WAIT_SOF. Reset mid-frame discards the frame with no `frame_done`.

## Timing
- `s_axis_video_tready` equals the value of `ready_en` from the previous `aclken` cycle; it is 0 during reset and on the first cycle after reset.
- All outputs are registered. Position, count and error outputs reflect a transfer on the cycle after it.
- `frame_done` is high for exactly one cycle, the cycle after the final transfer, aligned with the update of `frame_sig` and `frame_count`.
- No internal buffering: the block sustains one transfer per cycle while tready=1.
- When `aclken`=0: tready holds its value and no pulses are generated.

## Test plan
All scenarios use `FRAME_WIDTH`=8 and `FRAME_HEIGHT`=4.
- **Clean frame.** `ready_en`=1; 32 beats with tdata=n (n=0..31), tuser on beat 0, tlast on beats 7/15/23/31.
  - Expect `frame_done` once, the cycle after beat 31.
  - Expect `frame_count`=1, no errors, and `frame_sig` equal to the rotate-XOR of 0..31 computed by the bench model.
- **Pre-SOF junk.** 5 beats with tuser=0, then the clean frame.
  - Expect `drop_count`=5 and `frame_count`=1.
- **Early EOL.** tlast on beat 5 of line 0.
  - Expect `err_early_eol`=1 and `y_pos`=1 after that beat.
  - The frame still completes after 30 beats in total.
- **Missing EOL.** tlast withheld on beat 7.
  - Expect `err_late_eol`=1 and the line advances anyway.
  - A `clear_err` pulse afterwards returns all error flags to 0.
- **Mid-frame SOF.** tuser asserted on beat 12.
  - Expect `err_sof_mid`=1 and `x_pos`=1, `y_pos`=0.
  - `frame_count` increments only after 31 further beats.
- **Backpressure and reset.** Toggle `ready_en` 1,0,0,1 with tvalid held at 1.
  - Expect tready lagging `ready_en` by 1 cycle and no transfer while tready=0.
  - Assert aresetn=0 at beat 10: all outputs return to 0, and the next tuser starts a fresh frame.

Source files
------------

// File: rtl/axis_video_sink_monitor.sv
// AXI4-Stream video sink that terminates a video pipeline and checks its framing.
// Tracks pixel/line position from SOF/EOL, raises sticky framing errors and signs each frame.
module axis_video_sink_monitor #(
  parameter int DATA_WIDTH   = 64,
  parameter int FRAME_WIDTH  = 1920,
  parameter int FRAME_HEIGHT = 1080
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  aclken,
  input  logic [DATA_WIDTH-1:0] s_axis_video_tdata,
  input  logic                  s_axis_video_tvalid,
  output logic                  s_axis_video_tready,
  input  logic                  s_axis_video_tuser,
  input  logic                  s_axis_video_tlast,
  input  logic                  ready_en,
  input  logic                  clear_err,
  output logic [15:0]           x_pos,
  output logic [15:0]           y_pos,
  output logic [31:0]           frame_count,
  output logic [15:0]           drop_count,
  output logic [31:0]           frame_sig,
  output logic                  frame_done,
  output logic                  err_early_eol,
  output logic                  err_late_eol,
  output logic                  err_sof_mid
);

  localparam logic [15:0] X_LAST = 16'(FRAME_WIDTH - 1);
  localparam logic [15:0] Y_LAST = 16'(FRAME_HEIGHT - 1);

  typedef enum logic {
    WAIT_SOF = 1'b0,
    IN_FRAME = 1'b1
  } state_t;

  state_t      state;
  logic [31:0] sig;

  logic        xfer;
  logic        accept;
  logic        drop_ev;
  logic        sof_mid_set;
  logic        early_set;
  logic        late_set;
  logic [15:0] cur_x;
  logic [15:0] cur_y;
  logic [31:0] pix;
  logic [31:0] sig_next;
  logic        at_end;
  logic        line_end;
  logic        frame_end;
  logic [15:0] drop_base;

  // Only the low 32 data bits feed the signature; the rest are deliberately ignored.
  if (DATA_WIDTH > 32) begin : g_unused
    logic unused_tdata_hi;
    assign unused_tdata_hi = ^s_axis_video_tdata[DATA_WIDTH-1:32];
  end

  // A SOF beat is evaluated as position (0,0) of a freshly seeded frame, so a
  // tuser+tlast beat is checked for EOL at x=0 just like any other first pixel.
  always_comb begin
    pix         = s_axis_video_tdata[31:0];
    xfer        = aclken & s_axis_video_tvalid & s_axis_video_tready;
    accept      = xfer & (s_axis_video_tuser | (state == IN_FRAME));
    drop_ev     = xfer & ~s_axis_video_tuser & (state == WAIT_SOF);
    sof_mid_set = xfer & s_axis_video_tuser & (state == IN_FRAME);
    cur_x       = s_axis_video_tuser ? 16'd0 : x_pos;
    cur_y       = s_axis_video_tuser ? 16'd0 : y_pos;
    sig_next    = s_axis_video_tuser ? pix : ({sig[30:0], sig[31]} ^ pix);
    at_end      = (cur_x == X_LAST);
    line_end    = s_axis_video_tlast | at_end;
    frame_end   = line_end & (cur_y == Y_LAST);
    early_set   = accept & s_axis_video_tlast & ~at_end;
    late_set    = accept & at_end & ~s_axis_video_tlast;
    drop_base   = clear_err ? 16'd0 : drop_count;
  end

  // Sticky errors: a new error in the same cycle as clear_err keeps the flag set.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state               <= WAIT_SOF;
      sig                 <= 32'd0;
      s_axis_video_tready <= 1'b0;
      x_pos               <= 16'd0;
      y_pos               <= 16'd0;
      frame_count         <= 32'd0;
      drop_count          <= 16'd0;
      frame_sig           <= 32'd0;
      frame_done          <= 1'b0;
      err_early_eol       <= 1'b0;
      err_late_eol        <= 1'b0;
      err_sof_mid         <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (aclken) begin
        s_axis_video_tready <= ready_en;
        err_early_eol <= (err_early_eol & ~clear_err) | early_set;
        err_late_eol  <= (err_late_eol & ~clear_err) | late_set;
        err_sof_mid   <= (err_sof_mid & ~clear_err) | sof_mid_set;

        if (drop_ev) begin
          drop_count <= (drop_base == 16'hFFFF) ? 16'hFFFF : drop_base + 16'd1;
        end else begin
          drop_count <= drop_base;
        end

        if (accept) begin
          sig <= sig_next;
          if (frame_end) begin
            state       <= WAIT_SOF;
            frame_sig   <= sig_next;
            frame_count <= frame_count + 32'd1;
            frame_done  <= 1'b1;
            x_pos       <= 16'd0;
            y_pos       <= 16'd0;
          end else if (line_end) begin
            state <= IN_FRAME;
            x_pos <= 16'd0;
            y_pos <= cur_y + 16'd1;
          end else begin
            state <= IN_FRAME;
            x_pos <= cur_x + 16'd1;
            y_pos <= cur_y;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_axis_video_sink_monitor.sv
// Randomized and directed bench for axis_video_sink_monitor against a frame-level reference model.
// The model keeps each frame's pixels in a queue and signs the whole frame when it completes.
module tb_axis_video_sink_monitor;

  localparam int FW = 8;
  localparam int FH = 4;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic        aclken = 1'b1;
  logic [63:0] tdata = '0;
  logic        tvalid = 1'b0;
  logic        tready;
  logic        tuser = 1'b0;
  logic        tlast = 1'b0;
  logic        ready_en = 1'b0;
  logic        clear_err = 1'b0;
  logic [15:0] x_pos;
  logic [15:0] y_pos;
  logic [31:0] frame_count;
  logic [15:0] drop_count;
  logic [31:0] frame_sig;
  logic        frame_done;
  logic        err_early_eol;
  logic        err_late_eol;
  logic        err_sof_mid;

  int vectors = 0;
  int miscompares = 0;

  axis_video_sink_monitor #(
    .DATA_WIDTH(64), .FRAME_WIDTH(FW), .FRAME_HEIGHT(FH)
  ) dut (
    .aclk(aclk), .aresetn(aresetn), .aclken(aclken),
    .s_axis_video_tdata(tdata), .s_axis_video_tvalid(tvalid),
    .s_axis_video_tready(tready), .s_axis_video_tuser(tuser),
    .s_axis_video_tlast(tlast), .ready_en(ready_en), .clear_err(clear_err),
    .x_pos(x_pos), .y_pos(y_pos), .frame_count(frame_count),
    .drop_count(drop_count), .frame_sig(frame_sig), .frame_done(frame_done),
    .err_early_eol(err_early_eol), .err_late_eol(err_late_eol),
    .err_sof_mid(err_sof_mid)
  );

  always #5 aclk = ~aclk;

  // Reference model state
  logic [31:0] m_q[$];
  bit          m_tready, m_inFrame, m_done, m_early, m_late, m_sofMid, m_lastXfer;
  int          m_x, m_y, m_drop;
  logic [31:0] m_count, m_sig;

  function automatic logic [31:0] foldSig();
    logic [31:0] s;
    s = m_q[0];
    for (int i = 1; i < m_q.size(); i++) s = {s[30:0], s[31]} ^ m_q[i];
    return s;
  endfunction

  task automatic modelLine(input bit l);
    bit atEnd;
    atEnd = (m_x == FW - 1);
    if (l && !atEnd) m_early = 1;
    if (atEnd && !l) m_late = 1;
    if (l || atEnd) begin
      if (m_y == FH - 1) begin
        m_sig = foldSig();
        m_count++;
        m_done = 1;
        m_inFrame = 0;
        m_x = 0;
        m_y = 0;
      end else begin
        m_x = 0;
        m_y++;
      end
    end else begin
      m_x++;
    end
  endtask

  task automatic modelStep(input bit v, input logic [31:0] d, input bit u, input bit l,
                           input bit ren, input bit cen, input bit clr);
    m_done = 0;
    m_lastXfer = 0;
    if (!aresetn) begin
      m_tready = 0; m_inFrame = 0; m_x = 0; m_y = 0; m_drop = 0;
      m_count = 0; m_sig = 0; m_early = 0; m_late = 0; m_sofMid = 0;
      m_q.delete();
    end else if (cen) begin
      m_lastXfer = v && m_tready;
      if (clr) begin
        m_early = 0; m_late = 0; m_sofMid = 0; m_drop = 0;
      end
      if (m_lastXfer) begin
        if (u) begin
          if (m_inFrame) m_sofMid = 1;
          m_q.delete();
          m_q.push_back(d);
          m_x = 0;
          m_y = 0;
          m_inFrame = 1;
          modelLine(l);
        end else if (!m_inFrame) begin
          if (m_drop < 65535) m_drop++;
        end else begin
          m_q.push_back(d);
          modelLine(l);
        end
      end
      m_tready = ren;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  task automatic checkAll();
    checkOutput("tready", 32'(tready), 32'(m_tready));
    checkOutput("x_pos", 32'(x_pos), 32'(m_x));
    checkOutput("y_pos", 32'(y_pos), 32'(m_y));
    checkOutput("frame_count", frame_count, m_count);
    checkOutput("drop_count", 32'(drop_count), 32'(m_drop));
    checkOutput("frame_sig", frame_sig, m_sig);
    checkOutput("frame_done", 32'(frame_done), 32'(m_done));
    checkOutput("err_early_eol", 32'(err_early_eol), 32'(m_early));
    checkOutput("err_late_eol", 32'(err_late_eol), 32'(m_late));
    checkOutput("err_sof_mid", 32'(err_sof_mid), 32'(m_sofMid));
  endtask

  // Drive one cycle of inputs, advance the model across the edge, then compare.
  task automatic applyStimulus(input bit v, input logic [31:0] d, input bit u, input bit l,
                               input bit ren, input bit cen, input bit clr);
    tvalid = v; tdata = {$urandom(), d}; tuser = u; tlast = l;
    ready_en = ren; aclken = cen; clear_err = clr;
    @(posedge aclk);
    modelStep(v, d, u, l, ren, cen, clr);
    #1;
    checkAll();
  endtask

  task automatic sendBeat(input logic [31:0] d, input bit u, input bit l);
    applyStimulus(1, d, u, l, 1, 1, 0);
  endtask

  task automatic idle(input bit clr);
    applyStimulus(0, 32'd0, 0, 0, 1, 1, clr);
  endtask

  task automatic doReset();
    aresetn = 0;
    applyStimulus(0, 32'd0, 0, 0, 1, 1, 0);
    applyStimulus(0, 32'd0, 0, 0, 1, 1, 0);
    aresetn = 1;
    idle(0);
  endtask

  task automatic sendFrame(input logic [31:0] base);
    for (int n = 0; n < FW * FH; n++) sendBeat(base + 32'(n), n == 0, (n % FW) == FW - 1);
  endtask

  initial begin
    int k;
    bit u, l;

    // Clean frame
    doReset();
    checkOutput("first_tready", 32'(tready), 32'd1);
    sendFrame(32'd0);
    checkOutput("clean_done", 32'(frame_done), 32'd1);
    checkOutput("clean_count", frame_count, 32'd1);
    idle(0);
    checkOutput("clean_done_once", 32'(frame_done), 32'd0);

    // Pre-SOF junk
    doReset();
    for (int n = 0; n < 5; n++) sendBeat(32'hA0 + 32'(n), 0, 0);
    sendFrame(32'd100);
    checkOutput("junk_drop", 32'(drop_count), 32'd5);
    checkOutput("junk_count", frame_count, 32'd1);

    // Early EOL on beat 5 of line 0; frame finishes after 30 beats
    doReset();
    for (int n = 0; n < 6; n++) sendBeat(32'(n), n == 0, n == 5);
    checkOutput("early_flag", 32'(err_early_eol), 32'd1);
    checkOutput("early_y", 32'(y_pos), 32'd1);
    for (int n = 6; n < 30; n++) sendBeat(32'(n), 0, ((n - 6) % FW) == FW - 1);
    checkOutput("early_count", frame_count, 32'd1);

    // Missing EOL on beat 7, then clear_err
    doReset();
    for (int n = 0; n < FW * FH; n++) begin
      sendBeat(32'(n * 3), n == 0, ((n % FW) == FW - 1) && n != 7);
      if (n == 7) begin
        checkOutput("late_flag", 32'(err_late_eol), 32'd1);
        checkOutput("late_y", 32'(y_pos), 32'd1);
      end
    end
    idle(1);
    checkOutput("clr_late", 32'(err_late_eol), 32'd0);

    // Mid-frame SOF on beat 12
    doReset();
    for (int n = 0; n < 12; n++) sendBeat(32'(n), n == 0, (n % FW) == FW - 1);
    sendBeat(32'h55, 1, 0);
    checkOutput("sof_flag", 32'(err_sof_mid), 32'd1);
    checkOutput("sof_x", 32'(x_pos), 32'd1);
    checkOutput("sof_y", 32'(y_pos), 32'd0);
    for (int n = 1; n < FW * FH; n++) begin
      checkOutput("sof_count_hold", frame_count, 32'd0);
      sendBeat(32'(n + 7), 0, (n % FW) == FW - 1);
    end
    checkOutput("sof_count", frame_count, 32'd1);

    // Backpressure pattern, then reset at beat 10
    doReset();
    k = 0;
    for (int c = 0; c < 60 && k < 10; c++) begin
      applyStimulus(1, 32'(k), k == 0, (k % FW) == FW - 1, (c % 4) == 0 || (c % 4) == 3, 1, 0);
      if (m_lastXfer) k++;
    end
    checkOutput("bp_beats", 32'(k), 32'd10);
    aresetn = 0;
    applyStimulus(1, 32'd10, 0, 0, 1, 1, 0);
    checkOutput("rst_x", 32'(x_pos), 32'd0);
    checkOutput("rst_y", 32'(y_pos), 32'd0);
    checkOutput("rst_tready", 32'(tready), 32'd0);
    aresetn = 1;
    idle(0);
    sendFrame(32'd200);
    checkOutput("rst_count", frame_count, 32'd1);

    // Randomized traffic with clock-enable gaps, clears and framing faults
    doReset();
    for (int c = 0; c < 1500; c++) begin
      u = !m_inFrame ? ($urandom_range(0, 9) < 8) : ($urandom_range(0, 59) == 0);
      l = (m_x == FW - 1 || (u && FW == 1)) ? ($urandom_range(0, 19) != 0)
                                             : ($urandom_range(0, 39) == 0);
      applyStimulus($urandom_range(0, 9) < 8, $urandom(), u, l,
                    $urandom_range(0, 9) < 8, $urandom_range(0, 9) < 9,
                    $urandom_range(0, 29) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
